// File: rtl/tilt_pkg.sv
// Shared constants and types for the tilt indicator: glyph codes, digit count,
// window FSM states and the latched result mode.
package tilt_pkg;

  localparam logic [4:0] CODE_LEFT  = 5'd0;
  localparam logic [4:0] CODE_BAR   = 5'd1;
  localparam logic [4:0] CODE_RIGHT = 5'd15;
  localparam logic [4:0] CODE_EMPTY = 5'd31;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    UPDATE
  } state_t;

  typedef enum logic [1:0] {
    MODE_BLANK,
    MODE_LEVEL,
    MODE_LEFT,
    MODE_RIGHT
  } mode_t;

endpackage

// File: rtl/tilt_avg.sv
// Box-averages strobed signed samples over windows of 2^AVG_LOG2; avg_o is valid
// during the single UPDATE cycle, which also accepts sample 1 of the next window.
module tilt_avg
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sample_valid_i,
  input  logic signed [9:0] sample_i,
  output logic signed [9:0] avg_o,
  output logic              avg_valid_o
);

  localparam int ACC_W = 10 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  acc_shr;

  assign sample_ext = {{AVG_LOG2{sample_i[9]}}, sample_i};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sample_valid_i) begin
          acc_d   = sample_ext;
          cnt_d   = ONE_CNT;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (sample_valid_i) begin
          acc_d = acc_q + sample_ext;
          cnt_d = cnt_q + ONE_CNT;
          if (cnt_q == LAST_CNT) state_d = UPDATE;
        end
      end
      UPDATE: begin
        // The result is consumed this cycle, so the next window starts fresh here.
        state_d = ACCUM;
        if (sample_valid_i) begin
          acc_d = sample_ext;
          cnt_d = ONE_CNT;
        end else begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_shr     = acc_q >>> AVG_LOG2;
  assign avg_o       = acc_shr[9:0];
  assign avg_valid_o = (state_q == UPDATE);

endmodule

// File: rtl/tilt_indicator.sv
// Bubble-level indicator: maps each window average to six 5-bit seg7 glyph codes,
// pulses frame_valid per new pattern and blinks the indicator when tilt saturates.
module tilt_indicator
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2   = 4,
  parameter int DEADBAND   = 16,
  parameter int STEP_LOG2  = 5,
  parameter int BLINK_BITS = 22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_valid,
  input  logic signed [9:0]         sample,
  output logic [5*NUM_DIGITS-1:0]   digits,
  output logic                      frame_valid
);

  logic signed [9:0]          avg;
  logic                       avg_valid;
  logic [9:0]                 mag, excess, step;
  logic [1:0]                 k;
  mode_t                      mode_q, mode_d;
  logic [2:0]                 idx_q, idx_d;
  logic                       sat_q, sat_d;
  logic                       new_q, frame_q;
  logic [BLINK_BITS-1:0]      blink_q;
  logic [5*NUM_DIGITS-1:0]    digits_q, digits_d;
  logic                       blank_phase;

  tilt_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_valid_i (sample_valid),
    .sample_i       (sample),
    .avg_o          (avg),
    .avg_valid_o    (avg_valid)
  );

  // -512 has no positive 10-bit counterpart, so it reads as full-scale 511.
  always_comb begin
    if ($unsigned(avg) == 10'h200)
      mag = 10'd511;
    else if (avg[9])
      mag = $unsigned(-avg);
    else
      mag = $unsigned(avg);
    excess = mag - 10'(DEADBAND);
    step   = excess >> STEP_LOG2;
  end

  always_comb begin
    mode_d = MODE_LEVEL;
    idx_d  = 3'd0;
    sat_d  = 1'b0;
    k      = (step >= 10'd2) ? 2'd2 : step[1:0];
    if (mag >= 10'(DEADBAND)) begin
      sat_d = (step >= 10'd3);
      if (avg[9]) begin
        mode_d = MODE_LEFT;
        idx_d  = 3'd3 + {1'b0, k};
      end else begin
        mode_d = MODE_RIGHT;
        idx_d  = 3'd2 - {1'b0, k};
      end
    end
  end

  always_comb begin
    digits_d    = {NUM_DIGITS{CODE_EMPTY}};
    blank_phase = sat_q && !blink_q[BLINK_BITS-1];
    case (mode_q)
      MODE_LEVEL: begin
        digits_d[15 +: 5] = CODE_BAR;
        digits_d[10 +: 5] = CODE_BAR;
      end
      MODE_LEFT:  if (!blank_phase) digits_d[5*int'(idx_q) +: 5] = CODE_LEFT;
      MODE_RIGHT: if (!blank_phase) digits_d[5*int'(idx_q) +: 5] = CODE_RIGHT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_BLANK;
      idx_q    <= 3'd0;
      sat_q    <= 1'b0;
      new_q    <= 1'b0;
      frame_q  <= 1'b0;
      blink_q  <= '0;
      digits_q <= '1;
    end else begin
      blink_q  <= blink_q + 1'b1;
      new_q    <= avg_valid;
      frame_q  <= new_q;
      digits_q <= digits_d;
      if (avg_valid) begin
        mode_q <= mode_d;
        idx_q  <= idx_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_q;

endmodule

// File: tb/tb_tilt_indicator.sv
// Directed bench for tilt_indicator: table of window vectors plus hand sequences
// for saturation blink, back-to-back windows and reset behaviour.
module tb_tilt_indicator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [9:0]  sample = 10'd0;
  logic [29:0] digits;
  logic        frame_valid;

  // Short blink period so both blink phases show up within a few hundred cycles.
  tilt_indicator #(.BLINK_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .digits       (digits),
    .frame_valid  (frame_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] bc;
  always @(posedge clk or posedge rst)
    if (rst) bc <= 8'd0;
    else     bc <= bc + 8'd1;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int          fv_n = 0;
  int          fv_cyc = 0;
  int          fv_prev_cyc = 0;
  logic [29:0] fv_dig = '0;
  always @(negedge clk)
    if (frame_valid) begin
      fv_n        = fv_n + 1;
      fv_prev_cyc = fv_cyc;
      fv_cyc      = cyc_n;
      fv_dig      = digits;
    end

  function automatic logic [29:0] mk(input int d5, input int d4, input int d3,
                                     input int d2, input int d1, input int d0);
    return {5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  task automatic check_v(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic drive_n(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sample_valid = 1'b1;
      sample       = 10'(v);
    end
  endtask

  task automatic tail;
    tick();
    sample_valid = 1'b0;
  endtask

  typedef struct {
    int          a;
    int          b;
    logic [29:0] exp;
  } vec_t;

  vec_t        tbl[12];
  logic [29:0] ones, level;
  logic [29:0] blink_pat[2];
  int          blink_val[2];
  int          n0, t_last;
  logic [7:0]  pb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    ones  = mk(31, 31, 31, 31, 31, 31);
    level = mk(31, 31, 1, 1, 31, 31);
    tbl[0]  = '{0,    0,    level};
    tbl[1]  = '{0,    -1,   level};
    tbl[2]  = '{-100, -100, mk(0, 31, 31, 31, 31, 31)};
    tbl[3]  = '{-40,  -40,  mk(31, 31, 0, 31, 31, 31)};
    tbl[4]  = '{50,   50,   mk(31, 31, 31, 31, 15, 31)};
    tbl[5]  = '{15,   15,   level};
    tbl[6]  = '{16,   16,   mk(31, 31, 31, 15, 31, 31)};
    tbl[7]  = '{-16,  -15,  mk(31, 31, 0, 31, 31, 31)};
    tbl[8]  = '{-48,  -48,  mk(31, 0, 31, 31, 31, 31)};
    tbl[9]  = '{111,  111,  mk(31, 31, 31, 31, 31, 15)};
    tbl[10] = '{-15,  -15,  level};
    tbl[11] = '{-47,  -47,  mk(31, 31, 0, 31, 31, 31)};
    blink_val[0] = -512;
    blink_pat[0] = mk(0, 31, 31, 31, 31, 31);
    blink_val[1] = 112;
    blink_pat[1] = mk(31, 31, 31, 31, 31, 15);

    repeat (3) tick();
    check_v("reset_digits", digits, ones);
    check_i("reset_frame", int'(frame_valid), 0);
    rst = 1'b0;
    repeat (3) tick();
    check_v("idle_digits", digits, ones);

    for (int i = 0; i < 12; i++) begin
      n0 = fv_n;
      drive_n(tbl[i].a, 15);
      drive_n(tbl[i].b, 1);
      tail();
      t_last = cyc_n;
      repeat (6) tick();
      check_i($sformatf("vec%0d_frames", i), fv_n - n0, 1);
      check_i($sformatf("vec%0d_latency", i), fv_cyc - t_last, 2);
      check_v($sformatf("vec%0d_pattern", i), fv_dig, tbl[i].exp);
      check_v($sformatf("vec%0d_hold", i), digits, tbl[i].exp);
    end

    for (int j = 0; j < 2; j++) begin
      n0 = fv_n;
      drive_n(blink_val[j], 16);
      tail();
      repeat (6) tick();
      check_i($sformatf("sat%0d_frames", j), fv_n - n0, 1);
      for (int c = 0; c < 300; c++) begin
        pb = bc - 8'd1;
        check_v($sformatf("sat%0d_blink_c%0d", j, c), digits, pb[7] ? blink_pat[j] : ones);
        tick();
      end
      n0 = fv_n;
      drive_n(0, 16);
      tail();
      repeat (6) tick();
      check_i($sformatf("unsat%0d_frames", j), fv_n - n0, 1);
      for (int c = 0; c < 300; c += 10) begin
        check_v($sformatf("unsat%0d_level_c%0d", j, c), digits, level);
        repeat (10) tick();
      end
    end

    n0 = fv_n;
    drive_n(200, 16);
    drive_n(0, 16);
    tail();
    repeat (6) tick();
    check_i("b2b_frames", fv_n - n0, 2);
    check_i("b2b_spacing", fv_cyc - fv_prev_cyc, 16);
    check_v("b2b_level", fv_dig, level);

    n0 = fv_n;
    drive_n(300, 8);
    @(negedge clk);
    sample_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_v("midrst_digits", digits, ones);
    check_i("midrst_frame", int'(frame_valid), 0);
    tick();
    rst = 1'b0;
    drive_n(0, 15);
    tail();
    repeat (5) tick();
    check_i("midrst_noframe", fv_n - n0, 0);
    check_v("midrst_blank", digits, ones);
    drive_n(0, 1);
    tail();
    t_last = cyc_n;
    repeat (6) tick();
    check_i("midrst_frames", fv_n - n0, 1);
    check_i("midrst_latency", fv_cyc - t_last, 2);
    check_v("midrst_level", fv_dig, level);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
